video_mode_controller: RTL and testbench

VIDEO_MODE_CONTROLLER -- requirements
Module: video_mode_controller

---
 rtl/video_mode_controller.sv | 133 +++++++++++++
 tb/tb_video_mode_controller.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/video_mode_controller.sv
// Video timing mode controller: shadow timing registers written through a
// ready/valid port, validated on commit and swapped into the active set on a frame boundary.
module video_mode_controller #(
   parameter int xresolution = 10,
   parameter int yresolution = 10,
   parameter int BlankFrames = 2,
   localparam int DW = (xresolution > yresolution) ? xresolution : yresolution
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   CfgValid,
   output logic                   CfgReady,
   input  logic [2:0]             CfgSelect,
   input  logic [DW-1:0]          CfgData,
   input  logic                   CfgCommit,
   input  logic                   LineEnd,
   input  logic                   FrameEnd,
   output logic [xresolution-1:0] HSynchPulse,
   output logic [xresolution-1:0] HFrontPorch,
   output logic [xresolution-1:0] HActiveVideo,
   output logic [xresolution-1:0] HBackPorch,
   output logic [yresolution-1:0] VSynchPulse,
   output logic [yresolution-1:0] VFrontPorch,
   output logic [yresolution-1:0] VActiveVideo,
   output logic [yresolution-1:0] VBackPorch,
   output logic                   VideoEnable,
   output logic                   ModeBusy,
   output logic                   ModeChanged,
   output logic                   CfgError
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] PENDING = 2'd1;
   localparam logic [1:0] BLANK   = 2'd2;

   localparam logic [xresolution-1:0] H_DEF [4] =
      '{xresolution'(96), xresolution'(16), xresolution'(640), xresolution'(48)};
   localparam logic [yresolution-1:0] V_DEF [4] =
      '{yresolution'(2), yresolution'(10), yresolution'(480), yresolution'(33)};

   logic [1:0]             state;
   logic [3:0]             frame_cnt;
   logic [xresolution-1:0] sh_h [4];
   logic [yresolution-1:0] sh_v [4];
   logic [xresolution-1:0] act_h [4];
   logic [yresolution-1:0] act_v [4];
   logic [xresolution-1:0] nh [4];
   logic [yresolution-1:0] nv [4];
   logic [xresolution+1:0] h_sum;
   logic [yresolution+1:0] v_sum;
   logic                   wr, cm, set_ok, frame_tick;

   assign frame_tick = LineEnd & FrameEnd;
   assign CfgReady   = (state == IDLE);
   assign ModeBusy   = (state != IDLE);

   // Shadow set as it will look after this edge, so a same-cycle write is
   // included in the commit check.
   always_comb begin
      wr     = CfgValid  && (state == IDLE);
      cm     = CfgCommit && (state == IDLE);
      h_sum  = '0;
      v_sum  = '0;
      set_ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         nh[i] = (wr && CfgSelect == 3'(i))     ? CfgData[xresolution-1:0] : sh_h[i];
         nv[i] = (wr && CfgSelect == 3'(i + 4)) ? CfgData[yresolution-1:0] : sh_v[i];
         h_sum = h_sum + (xresolution+2)'(nh[i]);
         v_sum = v_sum + (yresolution+2)'(nv[i]);
         if (nh[i] == '0 || nv[i] == '0) set_ok = 1'b0;
      end
      if (h_sum[xresolution+1:xresolution] != 2'b00) set_ok = 1'b0;
      if (v_sum[yresolution+1:yresolution] != 2'b00) set_ok = 1'b0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         frame_cnt   <= '0;
         sh_h        <= H_DEF;
         sh_v        <= V_DEF;
         act_h       <= H_DEF;
         act_v       <= V_DEF;
         VideoEnable <= 1'b1;
         ModeChanged <= 1'b0;
         CfgError    <= 1'b0;
      end else begin
         sh_h        <= nh;
         sh_v        <= nv;
         ModeChanged <= 1'b0;
         case (state)
            IDLE: begin
               if (cm) begin
                  CfgError <= !set_ok;
                  if (set_ok) state <= PENDING;
               end else if (wr) begin
                  CfgError <= 1'b0;
               end
            end
            PENDING: begin
               if (frame_tick) begin
                  act_h       <= sh_h;
                  act_v       <= sh_v;
                  ModeChanged <= 1'b1;
                  VideoEnable <= 1'b0;
                  frame_cnt   <= '0;
                  state       <= BLANK;
               end
            end
            BLANK: begin
               if (frame_tick) begin
                  frame_cnt <= frame_cnt + 4'd1;
                  if (frame_cnt + 4'd1 == 4'(BlankFrames)) begin
                     state       <= IDLE;
                     VideoEnable <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign HSynchPulse  = act_h[0];
   assign HFrontPorch  = act_h[1];
   assign HActiveVideo = act_h[2];
   assign HBackPorch   = act_h[3];
   assign VSynchPulse  = act_v[0];
   assign VFrontPorch  = act_v[1];
   assign VActiveVideo = act_v[2];
   assign VBackPorch   = act_v[3];

endmodule

// File: tb/tb_video_mode_controller.sv
// Directed, table-driven bench for video_mode_controller: per-cycle vectors with
// hand-computed expected outputs, plus a hand-written asynchronous reset sequence.
module tb_video_mode_controller;

   logic       clock = 1'b0;
   logic       reset;
   logic       CfgValid, CfgCommit, LineEnd, FrameEnd, CfgReady;
   logic [2:0] CfgSelect;
   logic [9:0] CfgData;
   logic [9:0] HSynchPulse, HFrontPorch, HActiveVideo, HBackPorch;
   logic [9:0] VSynchPulse, VFrontPorch, VActiveVideo, VBackPorch;
   logic       VideoEnable, ModeBusy, ModeChanged, CfgError;

   int checks = 0;
   int passes = 0;

   always #5 clock = ~clock;

   video_mode_controller dut (
      .clock(clock), .reset(reset), .CfgValid(CfgValid), .CfgReady(CfgReady),
      .CfgSelect(CfgSelect), .CfgData(CfgData), .CfgCommit(CfgCommit),
      .LineEnd(LineEnd), .FrameEnd(FrameEnd),
      .HSynchPulse(HSynchPulse), .HFrontPorch(HFrontPorch),
      .HActiveVideo(HActiveVideo), .HBackPorch(HBackPorch),
      .VSynchPulse(VSynchPulse), .VFrontPorch(VFrontPorch),
      .VActiveVideo(VActiveVideo), .VBackPorch(VBackPorch),
      .VideoEnable(VideoEnable), .ModeBusy(ModeBusy),
      .ModeChanged(ModeChanged), .CfgError(CfgError)
   );

   typedef struct {
      int v, sel, d, c, le, fe;
      int rdy, busy, chg, ve, err, hact, vact;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      else passes++;
   endtask

   task automatic chk_defaults(input string tag);
      chk({tag, " HSynch"},  int'(HSynchPulse),  96);
      chk({tag, " HFront"},  int'(HFrontPorch),  16);
      chk({tag, " HActive"}, int'(HActiveVideo), 640);
      chk({tag, " HBack"},   int'(HBackPorch),   48);
      chk({tag, " VSynch"},  int'(VSynchPulse),  2);
      chk({tag, " VFront"},  int'(VFrontPorch),  10);
      chk({tag, " VActive"}, int'(VActiveVideo), 480);
      chk({tag, " VBack"},   int'(VBackPorch),   33);
      chk({tag, " VideoEnable"}, int'(VideoEnable), 1);
      chk({tag, " CfgReady"},    int'(CfgReady),    1);
      chk({tag, " ModeBusy"},    int'(ModeBusy),    0);
      chk({tag, " ModeChanged"}, int'(ModeChanged), 0);
      chk({tag, " CfgError"},    int'(CfgError),    0);
   endtask

   task automatic idle_inputs();
      CfgValid = 0; CfgSelect = 0; CfgData = 0; CfgCommit = 0; LineEnd = 0; FrameEnd = 0;
   endtask

   initial begin
      //            v sel    d  c le fe | rdy busy chg ve err hact vact
      vecs.push_back('{1, 2, 800, 0, 0, 0,  1, 0, 0, 1, 0, 640, 480}); // r0 write H active
      vecs.push_back('{1, 6, 600, 0, 0, 0,  1, 0, 0, 1, 0, 640, 480}); // r1 write V active
      vecs.push_back('{0, 0,   0, 1, 0, 0,  0, 1, 0, 1, 0, 640, 480}); // r2 commit
      vecs.push_back('{1, 2,   5, 0, 0, 0,  0, 1, 0, 1, 0, 640, 480}); // r3 write ignored
      vecs.push_back('{0, 0,   0, 0, 1, 0,  0, 1, 0, 1, 0, 640, 480}); // r4 LineEnd only
      vecs.push_back('{0, 0,   0, 0, 0, 1,  0, 1, 0, 1, 0, 640, 480}); // r5 FrameEnd only
      vecs.push_back('{0, 0,   0, 0, 0, 0,  0, 1, 0, 1, 0, 640, 480}); // r6
      vecs.push_back('{0, 0,   0, 0, 1, 1,  0, 1, 1, 0, 0, 800, 600}); // r7 swap
      vecs.push_back('{0, 0,   0, 0, 0, 0,  0, 1, 0, 0, 0, 800, 600}); // r8 pulse ends
      vecs.push_back('{0, 0,   0, 0, 1, 1,  0, 1, 0, 0, 0, 800, 600}); // r9 blank 1
      vecs.push_back('{0, 0,   0, 0, 1, 1,  1, 0, 0, 1, 0, 800, 600}); // r10 blank 2 -> idle
      vecs.push_back('{0, 0,   0, 0, 1, 1,  1, 0, 0, 1, 0, 800, 600}); // r11 tick in idle
      vecs.push_back('{1, 0,   0, 0, 0, 0,  1, 0, 0, 1, 0, 800, 600}); // r12 zero field
      vecs.push_back('{0, 0,   0, 1, 0, 0,  1, 0, 0, 1, 1, 800, 600}); // r13 commit rejected
      vecs.push_back('{0, 0,   0, 0, 1, 1,  1, 0, 0, 1, 1, 800, 600}); // r14 error sticky
      vecs.push_back('{1, 0,  96, 0, 0, 0,  1, 0, 0, 1, 0, 800, 600}); // r15 write clears
      vecs.push_back('{1, 2,1000, 1, 0, 0,  1, 0, 0, 1, 1, 800, 600}); // r16 sum 1160
      vecs.push_back('{1, 2, 863, 1, 0, 0,  0, 1, 0, 1, 0, 800, 600}); // r17 sum 1023 ok
      vecs.push_back('{0, 0,   0, 0, 1, 1,  0, 1, 1, 0, 0, 863, 600}); // r18 swap
      vecs.push_back('{0, 0,   0, 0, 1, 1,  0, 1, 0, 0, 0, 863, 600}); // r19
      vecs.push_back('{0, 0,   0, 0, 1, 1,  1, 0, 0, 1, 0, 863, 600}); // r20 -> idle
      vecs.push_back('{0, 0,   0, 1, 1, 1,  0, 1, 0, 1, 0, 863, 600}); // r21 commit+tick
      vecs.push_back('{0, 0,   0, 0, 1, 1,  0, 1, 1, 0, 0, 863, 600}); // r22 re-apply
      vecs.push_back('{0, 0,   0, 0, 1, 1,  0, 1, 0, 0, 0, 863, 600}); // r23 mid-blank

      idle_inputs();
      reset = 1'b1;
      #12;
      chk_defaults("reset");
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         CfgValid  = vecs[i].v[0];
         CfgSelect = vecs[i].sel[2:0];
         CfgData   = vecs[i].d[9:0];
         CfgCommit = vecs[i].c[0];
         LineEnd   = vecs[i].le[0];
         FrameEnd  = vecs[i].fe[0];
         @(posedge clock);
         #1;
         chk($sformatf("r%0d CfgReady", i),     int'(CfgReady),     vecs[i].rdy);
         chk($sformatf("r%0d ModeBusy", i),     int'(ModeBusy),     vecs[i].busy);
         chk($sformatf("r%0d ModeChanged", i),  int'(ModeChanged),  vecs[i].chg);
         chk($sformatf("r%0d VideoEnable", i),  int'(VideoEnable),  vecs[i].ve);
         chk($sformatf("r%0d CfgError", i),     int'(CfgError),     vecs[i].err);
         chk($sformatf("r%0d HActiveVideo", i), int'(HActiveVideo), vecs[i].hact);
         chk($sformatf("r%0d VActiveVideo", i), int'(VActiveVideo), vecs[i].vact);
      end
      chk("swap HSynch kept", int'(HSynchPulse), 96);
      chk("swap VBack kept",  int'(VBackPorch),  33);

      // Asynchronous reset in the middle of blanking, away from any clock edge.
      idle_inputs();
      #2;
      reset = 1'b1;
      #1;
      chk_defaults("async reset");
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         LineEnd = 1'b1; FrameEnd = 1'b1;
         @(posedge clock);
         #1;
         chk($sformatf("post-reset %0d ModeChanged", i), int'(ModeChanged), 0);
         chk($sformatf("post-reset %0d VideoEnable", i), int'(VideoEnable), 1);
         chk($sformatf("post-reset %0d ModeBusy", i),    int'(ModeBusy),    0);
         chk($sformatf("post-reset %0d HActive", i),     int'(HActiveVideo), 640);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
